// File: rtl/pps_in_monitor_pkg.sv
// Shared constants, FSM encoding and time-delta helper for the PPS input monitor.
package pps_in_monitor_pkg;

    localparam logic [31:0] SC2NS      = 32'd1_000_000_000;
    localparam logic [31:0] HALF_SC2NS = 32'd500_000_000;
    localparam logic [31:0] PERIOD_NA  = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HUNT,
        ST_CHECK,
        ST_LOCKED
    } pps_state_t;

    // Bit 32 flags a measurable delta (seconds apart by 0 or 1); otherwise the value is all ones.
    function automatic logic [32:0] ns_delta(input logic [79:0] t_new, input logic [79:0] t_old);
        logic [47:0] dsec;
        dsec = t_new[79:32] - t_old[79:32];
        if (dsec == 48'd0)
            return {1'b1, t_new[31:0] - t_old[31:0]};
        else if (dsec == 48'd1)
            return {1'b1, t_new[31:0] + SC2NS - t_old[31:0]};
        else
            return {1'b0, PERIOD_NA};
    endfunction

endpackage

// File: rtl/pps_in_monitor_deglitch.sv
// Level filter: the output follows the input only after FILT_LEN consecutive differing cycles.
module pps_deglitch #(
    parameter int unsigned FILT_LEN = 4
) (
    input  logic rtc_clk,
    input  logic rtc_rst,
    input  logic din,
    output logic dout
);

    localparam int unsigned CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge rtc_clk or posedge rtc_rst) begin
        if (rtc_rst) begin
            cnt  <= '0;
            dout <= 1'b0;
        end else if (din == dout) begin
            cnt <= '0;
        end else if (cnt == CW'(FILT_LEN - 1)) begin
            cnt  <= '0;
            dout <= din;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pps_in_monitor.sv
// 1PPS input qualifier: latency-compensated edge timestamp, period/phase measurement and lock FSM.
// Define PPS_DEGLITCH_EN to insert the pps_deglitch filter after the synchroniser.
module pps_in_monitor
    import pps_in_monitor_pkg::*;
#(
    parameter logic [31:0] PERIOD_TOL_NS = 32'd1000,
    parameter int unsigned LOCK_CNT      = 3,
    parameter int unsigned LOSS_CNT      = 2,
    parameter int unsigned FILT_LEN      = 4
) (
    input  logic        rtc_clk,
    input  logic        rtc_rst,
    input  logic        enable_i,
    input  logic [31:0] tick_inc_i,
    input  logic [79:0] rtc_std_i,
    input  logic        pps_i,
    input  logic        err_clr_i,
    output logic [79:0] pts_std_o,
    output logic [31:0] phase_err_o,
    output logic [31:0] period_o,
    output logic        evt_valid_o,
    output logic        missing_o,
    output logic        locked_o,
    output logic [15:0] err_cnt_o
);

`ifdef PPS_DEGLITCH_EN
    localparam bit DEGLITCH = 1'b1;
`else
    localparam bit DEGLITCH = 1'b0;
`endif
    localparam int unsigned LAT      = DEGLITCH ? 3 + FILT_LEN : 3;
    localparam logic [31:0] PER_MIN  = SC2NS - PERIOD_TOL_NS;
    localparam logic [31:0] PER_MAX  = SC2NS + PERIOD_TOL_NS;

    logic        d1, d2, d3, lvl, edge_det;
    logic [31:0] comp;
    logic [79:0] comp_ts;
    logic        s1_valid;
    logic [79:0] s1_ts;
    logic [79:0] last_ts, wd_ref;
    logic        last_valid;
    logic [32:0] per_raw, elapsed;
    logic [31:0] period_val, phase_val;
    logic        good_edge, expire, err_inc;
    logic [7:0]  good_cnt, bad_cnt;
    pps_state_t  state;
    logic        unused_tick_frac;

    always_comb unused_tick_frac = ^tick_inc_i[25:0];

    always_ff @(posedge rtc_clk or posedge rtc_rst) begin
        if (rtc_rst) begin
            d1 <= 1'b0;
            d2 <= 1'b0;
            d3 <= 1'b0;
        end else begin
            d1 <= pps_i;
            d2 <= d1;
            d3 <= lvl;
        end
    end

`ifdef PPS_DEGLITCH_EN
    pps_deglitch #(.FILT_LEN(FILT_LEN)) u_deglitch (
        .rtc_clk (rtc_clk),
        .rtc_rst (rtc_rst),
        .din     (d2),
        .dout    (lvl)
    );
`else
    always_comb lvl = d2;
`endif

    always_comb edge_det = lvl & ~d3;

    // Timestamp taken in the edge-detect cycle, pulled back by the input latency.
    always_comb begin
        comp    = 32'(LAT) * {26'd0, tick_inc_i[31:26]};
        comp_ts = rtc_std_i;
        if (rtc_std_i[31:0] < comp) begin
            comp_ts[79:32] = rtc_std_i[79:32] - 48'd1;
            comp_ts[31:0]  = rtc_std_i[31:0] + SC2NS - comp;
        end else begin
            comp_ts[31:0]  = rtc_std_i[31:0] - comp;
        end
    end

    always_ff @(posedge rtc_clk or posedge rtc_rst) begin
        if (rtc_rst) begin
            s1_valid <= 1'b0;
            s1_ts    <= '0;
        end else begin
            s1_valid <= edge_det;
            if (edge_det)
                s1_ts <= comp_ts;
        end
    end

    always_comb begin
        per_raw    = ns_delta(s1_ts, last_ts);
        period_val = last_valid ? per_raw[31:0] : PERIOD_NA;
        good_edge  = (period_val >= PER_MIN) && (period_val <= PER_MAX);
        phase_val  = (s1_ts[31:0] < HALF_SC2NS) ? s1_ts[31:0] : s1_ts[31:0] - SC2NS;
        elapsed    = ns_delta(rtc_std_i, wd_ref);
        // An edge result in the same cycle takes priority over the watchdog.
        expire     = last_valid && !s1_valid && (!elapsed[32] || (elapsed[31:0] > PER_MAX));
        err_inc    = enable_i && ((state == ST_CHECK) || (state == ST_LOCKED)) &&
                     ((s1_valid && !good_edge) || expire);
    end

    always_ff @(posedge rtc_clk or posedge rtc_rst) begin
        if (rtc_rst) begin
            state       <= ST_IDLE;
            good_cnt    <= '0;
            bad_cnt     <= '0;
            last_valid  <= 1'b0;
            last_ts     <= '0;
            wd_ref      <= '0;
            evt_valid_o <= 1'b0;
            missing_o   <= 1'b0;
            pts_std_o   <= '0;
            phase_err_o <= '0;
            period_o    <= PERIOD_NA;
        end else begin
            evt_valid_o <= 1'b0;
            missing_o   <= 1'b0;
            if (!enable_i) begin
                state      <= ST_IDLE;
                good_cnt   <= '0;
                bad_cnt    <= '0;
                last_valid <= 1'b0;
            end else if (state == ST_IDLE) begin
                state <= ST_HUNT;
            end else if (s1_valid) begin
                evt_valid_o <= 1'b1;
                pts_std_o   <= s1_ts;
                phase_err_o <= phase_val;
                period_o    <= period_val;
                last_ts     <= s1_ts;
                wd_ref      <= s1_ts;
                last_valid  <= 1'b1;
                case (state)
                    ST_HUNT: begin
                        state    <= ST_CHECK;
                        good_cnt <= '0;
                    end
                    ST_CHECK: begin
                        if (!good_edge) begin
                            good_cnt <= '0;
                        end else if (32'(good_cnt) + 32'd1 >= LOCK_CNT) begin
                            state    <= ST_LOCKED;
                            good_cnt <= '0;
                            bad_cnt  <= '0;
                        end else begin
                            good_cnt <= good_cnt + 8'd1;
                        end
                    end
                    ST_LOCKED: begin
                        if (good_edge) begin
                            bad_cnt <= '0;
                        end else if (32'(bad_cnt) + 32'd1 >= LOSS_CNT) begin
                            state   <= ST_HUNT;
                            bad_cnt <= '0;
                        end else begin
                            bad_cnt <= bad_cnt + 8'd1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end else if (expire) begin
                missing_o <= 1'b1;
                wd_ref    <= rtc_std_i;
                if (state == ST_CHECK) begin
                    good_cnt <= '0;
                end else if (state == ST_LOCKED) begin
                    if (32'(bad_cnt) + 32'd1 >= LOSS_CNT) begin
                        state   <= ST_HUNT;
                        bad_cnt <= '0;
                    end else begin
                        bad_cnt <= bad_cnt + 8'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge rtc_clk or posedge rtc_rst) begin
        if (rtc_rst)
            err_cnt_o <= '0;
        else if (err_clr_i)
            err_cnt_o <= '0;
        else if (err_inc && (err_cnt_o != 16'hFFFF))
            err_cnt_o <= err_cnt_o + 16'd1;
    end

    always_comb locked_o = (state == ST_LOCKED);

endmodule
